// File: rtl/acc_vec_mul_seq_pkg.sv
// Shared constants, element types and FSM state encoding for the sequential
// 16-lane vector multiply engine (acc_vec_mul_seq).
package acc_vec_mul_seq_pkg;

    localparam int N_LANES         = 16;
    localparam int IN_WIDTH        = 8;
    localparam int OUT_WIDTH       = 16;
    localparam int LANES_PER_CYCLE = 4;

    // Number of RUN cycles needed to sweep every lane once.
    localparam int NCHUNK  = N_LANES / LANES_PER_CYCLE;
    localparam int CHUNK_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int LANE_W  = (N_LANES > 1) ? $clog2(N_LANES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        COMMIT = 2'd2
    } acc_state_e;

    typedef logic [IN_WIDTH-1:0]  acc_in_t;
    typedef logic [OUT_WIDTH-1:0] acc_out_t;
    typedef logic [CHUNK_W-1:0]   chunk_t;
    typedef logic [LANE_W-1:0]    lane_idx_t;

    // Vector lane served by multiplier slot 'slot' while chunk 'chunk' is active.
    function automatic lane_idx_t lane_index(input chunk_t chunk, input int slot);
        return lane_idx_t'(int'(chunk) * LANES_PER_CYCLE + slot);
    endfunction

endpackage

// File: rtl/acc_vec_mul_seq_if.sv
// Handshake and operand/result bus of acc_vec_mul_seq. The master side
// (register window / testbench) issues start/clear and operands; the slave
// side is the engine.
interface acc_vec_mul_seq_if;
    import acc_vec_mul_seq_pkg::*;

    logic                          start_i;
    logic                          clear_i;
    logic [N_LANES*IN_WIDTH-1:0]   acc_in_A_i;
    logic [N_LANES*IN_WIDTH-1:0]   acc_in_B_i;
    logic                          busy_o;
    logic                          done_o;
    logic [N_LANES*OUT_WIDTH-1:0]  acc_out_o;
    logic                          ovf_o;

    modport master (
        output start_i, clear_i, acc_in_A_i, acc_in_B_i,
        input  busy_o, done_o, acc_out_o, ovf_o
    );

    modport slave (
        input  start_i, clear_i, acc_in_A_i, acc_in_B_i,
        output busy_o, done_o, acc_out_o, ovf_o
    );

endinterface

// File: rtl/acc_vec_mul_seq_lane_mul.sv
// One combinational lane of the vector engine: unsigned A*B, zero-extended to
// the result width. With ACC_ACCUM_EN defined the product is added to the
// lane's committed value, wrapping, and the carry-out is reported.
module acc_vec_mul_seq_lane_mul
    import acc_vec_mul_seq_pkg::*;
(
    input  acc_in_t  a,
    input  acc_in_t  b,
`ifdef ACC_ACCUM_EN
    input  acc_out_t addend,
    output logic     carry,
`endif
    output acc_out_t result
);

    acc_out_t product_s;

    // Both operands are widened first so the full 2*IN_WIDTH product is kept.
    assign product_s = acc_out_t'(a) * acc_out_t'(b);

`ifdef ACC_ACCUM_EN
    logic [OUT_WIDTH:0] sum_s;

    assign sum_s  = {1'b0, addend} + {1'b0, product_s};
    assign result = sum_s[OUT_WIDTH-1:0];
    assign carry  = sum_s[OUT_WIDTH];
`else
    assign result = product_s;
`endif

endmodule

// File: rtl/acc_vec_mul_seq.sv
// Sequential vector multiply engine. Operands are snapshotted on an accepted
// start, LANES_PER_CYCLE lanes are computed per RUN cycle into a working
// vector, and the whole vector is copied to the visible result in one COMMIT
// cycle so readers never observe a partially updated vector.
// Optional feature macro: ACC_ACCUM_EN (accumulate into the committed result
// with a sticky overflow flag).
module acc_vec_mul_seq
    import acc_vec_mul_seq_pkg::*;
(
    input  logic             HCLK,
    input  logic             HRESETn,
    acc_vec_mul_seq_if.slave bus
);

    acc_state_e state_r;
    chunk_t     chunk_r;
    logic       busy_r;
    logic       done_r;

    acc_in_t    a_snap_r  [N_LANES];
    acc_in_t    b_snap_r  [N_LANES];
    acc_out_t   work_r    [N_LANES];
    acc_out_t   acc_out_r [N_LANES];

    lane_idx_t  lane_idx_s [LANES_PER_CYCLE];
    acc_in_t    lane_a_s   [LANES_PER_CYCLE];
    acc_in_t    lane_b_s   [LANES_PER_CYCLE];
    acc_out_t   lane_res_s [LANES_PER_CYCLE];

    logic [N_LANES*OUT_WIDTH-1:0] acc_out_flat_s;

    logic start_ok_s;
    logic clear_ok_s;
    logic last_chunk_s;

    // start and clear are only honoured while idle; both are dropped when busy.
    assign start_ok_s   = (state_r == IDLE) && bus.start_i;
    assign clear_ok_s   = (state_r == IDLE) && bus.clear_i;
    assign last_chunk_s = (chunk_r == chunk_t'(NCHUNK - 1));

`ifdef ACC_ACCUM_EN
    logic [LANES_PER_CYCLE-1:0] lane_carry_s;
    logic                       ovf_pend_r;
    logic                       ovf_r;
`endif

    // Multiplier slots, each steered to its lane of the active chunk.
    for (genvar g = 0; g < LANES_PER_CYCLE; g++) begin : g_lane
        assign lane_idx_s[g] = lane_index(chunk_r, g);
        assign lane_a_s[g]   = a_snap_r[lane_idx_s[g]];
        assign lane_b_s[g]   = b_snap_r[lane_idx_s[g]];

        acc_vec_mul_seq_lane_mul u_lane_mul (
            .a      (lane_a_s[g]),
            .b      (lane_b_s[g]),
`ifdef ACC_ACCUM_EN
            .addend (acc_out_r[lane_idx_s[g]]),
            .carry  (lane_carry_s[g]),
`endif
            .result (lane_res_s[g])
        );
    end

    // Control FSM: IDLE -> RUN on start, RUN sweeps the chunks, COMMIT publishes.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r <= IDLE;
            chunk_r <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start_ok_s) begin
                        state_r <= RUN;
                        chunk_r <= '0;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                RUN: begin
                    if (last_chunk_s) begin
                        state_r <= COMMIT;
                        chunk_r <= '0;
                        done_r  <= 1'b1;
                    end else begin
                        chunk_r <= chunk_r + chunk_t'(1);
                    end
                end
                COMMIT: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    chunk_r <= '0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Operand snapshot taken on the accepted start so later input changes are ignored.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < N_LANES; i++) begin
                a_snap_r[i] <= '0;
                b_snap_r[i] <= '0;
            end
        end else if (start_ok_s) begin
            for (int i = 0; i < N_LANES; i++) begin
                a_snap_r[i] <= bus.acc_in_A_i[i*IN_WIDTH +: IN_WIDTH];
                b_snap_r[i] <= bus.acc_in_B_i[i*IN_WIDTH +: IN_WIDTH];
            end
        end
    end

    // Working vector: the active chunk's lane results are written each RUN cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < N_LANES; i++) begin
                work_r[i] <= '0;
            end
        end else if (state_r == RUN) begin
            for (int j = 0; j < LANES_PER_CYCLE; j++) begin
                work_r[lane_idx_s[j]] <= lane_res_s[j];
            end
        end
    end

`ifdef ACC_ACCUM_EN
    // Collects lane carries of the running operation until they are published at COMMIT.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ovf_pend_r <= 1'b0;
        end else if (start_ok_s) begin
            ovf_pend_r <= 1'b0;
        end else if (state_r == RUN) begin
            ovf_pend_r <= ovf_pend_r | (|lane_carry_s);
        end
    end
`endif

    // Committed result: zeroed by clear, replaced as a whole vector at COMMIT.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < N_LANES; i++) begin
                acc_out_r[i] <= '0;
            end
`ifdef ACC_ACCUM_EN
            ovf_r <= 1'b0;
`endif
        end else if (clear_ok_s) begin
            for (int i = 0; i < N_LANES; i++) begin
                acc_out_r[i] <= '0;
            end
`ifdef ACC_ACCUM_EN
            ovf_r <= 1'b0;
`endif
        end else if (state_r == COMMIT) begin
            for (int i = 0; i < N_LANES; i++) begin
                acc_out_r[i] <= work_r[i];
            end
`ifdef ACC_ACCUM_EN
            ovf_r <= ovf_r | ovf_pend_r;
`endif
        end
    end

    // Flattens the committed lanes onto the result bus, lane i at bits [i*OUT_WIDTH +: OUT_WIDTH].
    always_comb begin
        acc_out_flat_s = '0;
        for (int i = 0; i < N_LANES; i++) begin
            acc_out_flat_s[i*OUT_WIDTH +: OUT_WIDTH] = acc_out_r[i];
        end
    end

    assign bus.busy_o    = busy_r;
    assign bus.done_o    = done_r;
    assign bus.acc_out_o = acc_out_flat_s;
`ifdef ACC_ACCUM_EN
    assign bus.ovf_o     = ovf_r;
`else
    assign bus.ovf_o     = 1'b0;
`endif

endmodule

// File: tb/tb_acc_vec_mul_seq.sv
// Self-checking bench for acc_vec_mul_seq: directed steps with random operands,
// compared against a lane-by-lane arithmetic model of the engine's results.
module tb_acc_vec_mul_seq;
    import acc_vec_mul_seq_pkg::*;

    localparam int VEC_IN_W  = N_LANES * IN_WIDTH;
    localparam int VEC_OUT_W = N_LANES * OUT_WIDTH;
    localparam int LATENCY   = NCHUNK + 1;
`ifdef ACC_ACCUM_EN
    localparam bit ACCUM = 1'b1;
`else
    localparam bit ACCUM = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    acc_vec_mul_seq_if bus ();

    acc_vec_mul_seq dut (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (bus)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    longint unsigned model_acc [N_LANES];
    bit              model_ovf;

    task automatic check(input string tag, input logic [VEC_OUT_W-1:0] obs,
                         input logic [VEC_OUT_W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < N_LANES; i++) model_acc[i] = 0;
        model_ovf = 1'b0;
    endfunction

    // Result of one operation: plain product, or wrapping accumulate with overflow.
    function automatic void model_op(input logic [VEC_IN_W-1:0] a, input logic [VEC_IN_W-1:0] b);
        longint unsigned ai, bi, s;
        longint unsigned lim;
        lim = 64'd1 << OUT_WIDTH;
        for (int i = 0; i < N_LANES; i++) begin
            ai = a[i*IN_WIDTH +: IN_WIDTH];
            bi = b[i*IN_WIDTH +: IN_WIDTH];
            s  = ai * bi;
            if (ACCUM) s = s + model_acc[i];
            if (s >= lim) model_ovf = 1'b1;
            model_acc[i] = s % lim;
        end
    endfunction

    function automatic logic [VEC_OUT_W-1:0] model_vec();
        logic [VEC_OUT_W-1:0] v;
        v = '0;
        for (int i = 0; i < N_LANES; i++) v[i*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(model_acc[i]);
        return v;
    endfunction

    function automatic logic [VEC_IN_W-1:0] rand_vec();
        logic [VEC_IN_W-1:0] v;
        for (int i = 0; i < N_LANES; i++)
            v[i*IN_WIDTH +: IN_WIDTH] = IN_WIDTH'($urandom_range(0, (1 << IN_WIDTH) - 1));
        return v;
    endfunction

    // One operation: start at cycle 0, busy/done checked every cycle, result after commit.
    // 'disturb' zeroes A at cycle 1, pulses start at cycle 2 and clear at cycle 3.
    task automatic do_op(input string tag, input logic [VEC_IN_W-1:0] a,
                         input logic [VEC_IN_W-1:0] b, input bit with_clear, input bit disturb);
        @(posedge clk); #1;
        bus.acc_in_A_i = a;
        bus.acc_in_B_i = b;
        bus.start_i    = 1'b1;
        bus.clear_i    = with_clear;
        if (with_clear) model_clear();
        model_op(a, b);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        bus.clear_i = 1'b0;
        for (int c = 1; c <= LATENCY + 3; c++) begin
            @(negedge clk);
            check($sformatf("%s busy@%0d", tag, c), bus.busy_o, (c <= LATENCY));
            check($sformatf("%s done@%0d", tag, c), bus.done_o, (c == LATENCY));
            if (disturb) begin
                if (c == 1) bus.acc_in_A_i = '0;
                bus.start_i = (c == 2);
                bus.clear_i = (c == 3);
            end
        end
        check({tag, " result"}, bus.acc_out_o, model_vec());
        check({tag, " ovf"}, bus.ovf_o, model_ovf);
    endtask

    initial begin
        logic [VEC_IN_W-1:0] va, vb;

        rst_n          = 1'b0;
        bus.start_i    = 1'b0;
        bus.clear_i    = 1'b0;
        bus.acc_in_A_i = '0;
        bus.acc_in_B_i = '0;
        model_clear();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst busy", bus.busy_o, 1'b0);
        check("rst done", bus.done_o, 1'b0);
        check("rst ovf", bus.ovf_o, 1'b0);
        check("rst acc_out", bus.acc_out_o, model_vec());
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("idle busy@%0d", c), bus.busy_o, 1'b0);
            check($sformatf("idle done@%0d", c), bus.done_o, 1'b0);
        end
        check("idle acc_out", bus.acc_out_o, model_vec());
        check("idle ovf", bus.ovf_o, 1'b0);

        // Basic: A[i]=i+1, B[i]=2
        for (int i = 0; i < N_LANES; i++) begin
            va[i*IN_WIDTH +: IN_WIDTH] = IN_WIDTH'(i + 1);
            vb[i*IN_WIDTH +: IN_WIDTH] = 8'd2;
        end
        do_op("basic", va, vb, 1'b0, 1'b0);

        // Max operands, from zeroed results, then again (accumulate wraps)
        va = '1;
        vb = '1;
        do_op("max1", va, vb, 1'b1, 1'b0);
        check("max1 lane0", {{(VEC_OUT_W-OUT_WIDTH){1'b0}}, bus.acc_out_o[OUT_WIDTH-1:0]}, 16'hFE01);
        do_op("max2", va, vb, 1'b0, 1'b0);

        // Operand stability and ignored start/clear while busy
        va = rand_vec();
        vb = rand_vec();
        do_op("stable", va, vb, 1'b0, 1'b1);

        // Clear alone
        @(posedge clk); #1;
        bus.clear_i = 1'b1;
        model_clear();
        @(posedge clk); #1;
        bus.clear_i = 1'b0;
        @(negedge clk);
        check("clear acc_out", bus.acc_out_o, model_vec());
        check("clear ovf", bus.ovf_o, 1'b0);

        // Random operands
        for (int k = 0; k < 4; k++) begin
            va = rand_vec();
            vb = rand_vec();
            do_op($sformatf("rand%0d", k), va, vb, 1'b0, 1'b0);
        end

        // Same-cycle clear and start: A=3, B=4
        for (int i = 0; i < N_LANES; i++) begin
            va[i*IN_WIDTH +: IN_WIDTH] = 8'd3;
            vb[i*IN_WIDTH +: IN_WIDTH] = 8'd4;
        end
        do_op("clr_start", va, vb, 1'b1, 1'b0);
        check("clr_start lane15",
              {{(VEC_OUT_W-OUT_WIDTH){1'b0}}, bus.acc_out_o[VEC_OUT_W-1 -: OUT_WIDTH]}, 16'd12);

        // Abort by reset at RUN cycle 3
        va = rand_vec();
        vb = rand_vec();
        @(posedge clk); #1;
        bus.acc_in_A_i = va;
        bus.acc_in_B_i = vb;
        bus.start_i    = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check($sformatf("abort done@%0d", c), bus.done_o, 1'b0);
        end
        rst_n = 1'b0;
        model_clear();
        #1;
        check("abort busy", bus.busy_o, 1'b0);
        check("abort acc_out", bus.acc_out_o, model_vec());
        check("abort ovf", bus.ovf_o, 1'b0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("abort hold done@%0d", c), bus.done_o, 1'b0);
        end
        rst_n = 1'b1;
        do_op("post_abort", va, vb, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
